// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit and data memory.
//   master (load/store unit): drives mem_req, mem_we, mem_addr, mem_wdata and mem_be.
//     It samples mem_ack and mem_rdata.
//   slave (memory): samples the request fields.
//     It drives mem_ack (a one-cycle pulse) and mem_rdata (valid only with mem_ack).
interface load_store_unit_if #(
  parameter int XLEN = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_be;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory stage: takes one load/store from execute and runs a req/ack transaction with data memory.
// For loads, the unit aligns and extends the returned data and writes it to the register file.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset.
//   ex_*            op from execute. ex_ready is high only while idle.
//   mem             data-memory bus (load_store_unit_if.master).
//   wb_*            register-file write port. wb_data and wb_add hold until the next load completes.
//   fault           one-cycle pulse when an op is rejected (illegal funct3 or misaligned).
//
// state  | meaning
// IDLE   | ready for an op; rejected ops pulse fault
// ACCESS | mem_req held with stable fields until mem_ack
// WB     | single register-file write cycle for a load
module load_store_unit #(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic             ex_load,
  input  logic             ex_store,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_addr,
  input  logic [XLEN-1:0]  ex_wdata,
  input  logic [RF_AW-1:0] ex_rd,
  load_store_unit_if.master mem,
  output logic             wb_en,
  output logic [RF_AW-1:0] wb_add,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_memtoreg,
  output logic             fault
);

  typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0]  addr_q;
  logic [2:0]       f3_q;
  logic [RF_AW-1:0] rd_q;
  logic             we_q;
  logic [3:0]       be_q;
  logic [XLEN-1:0]  wdata_q;
  logic [XLEN-1:0]  wb_data_q;
  logic [RF_AW-1:0] wb_add_q;
  logic             fault_q;

  logic             legal_f3, misalign, op_valid, op_accept, op_reject;
  logic [3:0]       st_be;
  logic [XLEN-1:0]  st_wdata;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [XLEN-1:0]  ld_ext;

  // Op decode in IDLE. When both ex_load and ex_store are set, the op is treated as a load.
  always_comb begin
    legal_f3 = 1'b0;
    misalign = 1'b0;
    st_be    = 4'b1111;
    st_wdata = ex_wdata;
    if (ex_load) begin
      case (ex_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_f3 = 1'b1;
        default:                                legal_f3 = 1'b0;
      endcase
    end else begin
      case (ex_funct3)
        3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
        default:                legal_f3 = 1'b0;
      endcase
      case (ex_funct3[1:0])
        2'b00: begin
          st_be    = 4'b0001 << ex_addr[1:0];
          st_wdata = {4{ex_wdata[7:0]}};
        end
        2'b01: begin
          st_be    = ex_addr[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{ex_wdata[15:0]}};
        end
        default: ;
      endcase
    end
    case (ex_funct3[1:0])
      2'b01:   misalign = ex_addr[0];
      2'b10:   misalign = |ex_addr[1:0];
      default: misalign = 1'b0;
    endcase
    op_valid  = ex_valid & (ex_load | ex_store);
    op_accept = op_valid & legal_f3 & ~misalign;
    op_reject = op_valid & ~(legal_f3 & ~misalign);
  end

  // Load lane select and extension, using the registered address and funct3.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = mem.mem_rdata[7:0];
      2'b01:   ld_byte = mem.mem_rdata[15:8];
      2'b10:   ld_byte = mem.mem_rdata[23:16];
      default: ld_byte = mem.mem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ex_ready    = 1'b0;
    mem.mem_req = 1'b0;
    wb_en       = 1'b0;
    wb_memtoreg = 1'b0;
    case (state_q)
      IDLE: begin
        ex_ready = 1'b1;
        if (op_accept) state_d = ACCESS;
      end
      ACCESS: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ack) state_d = we_q ? IDLE : WB;
      end
      WB: begin
        wb_memtoreg = 1'b1;
        wb_en       = |rd_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      wb_data_q <= '0;
      wb_add_q  <= '0;
      fault_q   <= 1'b0;
    end else begin
      fault_q <= (state_q == IDLE) & op_reject;
      if ((state_q == IDLE) && op_accept) begin
        addr_q  <= ex_addr;
        f3_q    <= ex_funct3;
        rd_q    <= ex_rd;
        we_q    <= ~ex_load;
        be_q    <= st_be;
        wdata_q <= st_wdata;
      end
      if ((state_q == ACCESS) && mem.mem_ack && !we_q) begin
        wb_data_q <= ld_ext;
        wb_add_q  <= rd_q;
      end
    end
  end

  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_be    = be_q;
  assign wb_data       = wb_data_q;
  assign wb_add        = wb_add_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit. Inputs change and outputs are sampled on the falling clock edge.
// Memory acks are driven by hand.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_load, ex_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        wb_en, wb_memtoreg, fault;
  logic [4:0]  wb_add;
  logic [31:0] wb_data;
  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;

  load_store_unit_if #(.XLEN(32)) mem_bus ();

  load_store_unit #(.XLEN(32), .RF_AW(5)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_load(ex_load), .ex_store(ex_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .mem(mem_bus),
    .wb_en(wb_en), .wb_add(wb_add), .wb_data(wb_data), .wb_memtoreg(wb_memtoreg),
    .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    ex_valid = 1'b1; ex_load = ld; ex_store = st;
    ex_funct3 = f3; ex_addr = addr; ex_wdata = wd; ex_rd = rd;
    @(negedge clk);
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
  endtask

  task automatic do_ack(input logic [31:0] rdata);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = rdata;
    @(negedge clk);
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'h0;
  endtask

  task automatic run_load(input string tag, input logic both, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [4:0] rd,
                          input logic [31:0] rdata, input logic [31:0] exp);
    check({tag, " ready_in"}, ex_ready, 1);
    issue(1'b1, both, f3, addr, 32'h5555_5555, rd);
    check({tag, " req"}, mem_bus.mem_req, 1);
    check({tag, " we"}, mem_bus.mem_we, 0);
    check({tag, " be"}, mem_bus.mem_be, 4'hF);
    check({tag, " addr"}, mem_bus.mem_addr, {addr[31:2], 2'b00});
    check({tag, " ready_busy"}, ex_ready, 0);
    @(negedge clk);
    check({tag, " req_hold"}, mem_bus.mem_req, 1);
    check({tag, " wb_en_early"}, wb_en, 0);
    do_ack(rdata);
    check({tag, " wb_en"}, wb_en, (rd != 5'd0) ? 1 : 0);
    check({tag, " memtoreg"}, wb_memtoreg, 1);
    check({tag, " wb_add"}, wb_add, rd);
    check({tag, " wb_data"}, wb_data, exp);
    check({tag, " ready_wb"}, ex_ready, 0);
    check({tag, " req_wb"}, mem_bus.mem_req, 0);
    @(negedge clk);
    check({tag, " wb_en_after"}, wb_en, 0);
    check({tag, " memtoreg_after"}, wb_memtoreg, 0);
    check({tag, " ready_after"}, ex_ready, 1);
    check({tag, " wb_data_hold"}, wb_data, exp);
    check({tag, " wb_add_hold"}, wb_add, rd);
  endtask

  task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int waits,
                           input logic [31:0] exp_wdata, input logic [3:0] exp_be);
    check({tag, " ready_in"}, ex_ready, 1);
    issue(1'b0, 1'b1, f3, addr, wd, 5'd9);
    for (int i = 0; i <= waits; i++) begin
      check({tag, " req"}, mem_bus.mem_req, 1);
      check({tag, " we"}, mem_bus.mem_we, 1);
      check({tag, " addr"}, mem_bus.mem_addr, {addr[31:2], 2'b00});
      check({tag, " wdata"}, mem_bus.mem_wdata, exp_wdata);
      check({tag, " be"}, mem_bus.mem_be, exp_be);
      check({tag, " wb_en_busy"}, wb_en, 0);
      if (i < waits) @(negedge clk);
    end
    do_ack(32'hFFFF_FFFF);
    check({tag, " req_done"}, mem_bus.mem_req, 0);
    check({tag, " ready_done"}, ex_ready, 1);
    check({tag, " wb_en_done"}, wb_en, 0);
  endtask

  task automatic run_reject(input string tag, input logic ld, input logic [2:0] f3,
                            input logic [31:0] addr);
    ex_valid = 1'b1; ex_load = ld; ex_store = ~ld;
    ex_funct3 = f3; ex_addr = addr; ex_wdata = 32'h1234_5678; ex_rd = 5'd4;
    @(negedge clk);
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
    check({tag, " fault"}, fault, 1);
    check({tag, " req"}, mem_bus.mem_req, 0);
    check({tag, " ready"}, ex_ready, 1);
    @(negedge clk);
    check({tag, " fault_clear"}, fault, 0);
    check({tag, " req_idle"}, mem_bus.mem_req, 0);
    check({tag, " wb_en"}, wb_en, 0);
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
    ex_funct3 = 3'b000; ex_addr = 32'h0; ex_wdata = 32'h0; ex_rd = 5'd0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'h0;
    #2 rst = 1'b0;
    #1;
    check("rst ready", ex_ready, 1);
    check("rst req", mem_bus.mem_req, 0);
    check("rst we", mem_bus.mem_we, 0);
    check("rst addr", mem_bus.mem_addr, 0);
    check("rst wdata", mem_bus.mem_wdata, 0);
    check("rst be", mem_bus.mem_be, 0);
    check("rst wb_en", wb_en, 0);
    check("rst wb_add", wb_add, 0);
    check("rst wb_data", wb_data, 0);
    check("rst memtoreg", wb_memtoreg, 0);
    check("rst fault", fault, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_store("sw", 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 4'b1111);
    run_load("lb", 1'b0, 3'b000, 32'h0000_0203, 5'd13, 32'h80FF_1234, 32'hFFFF_FF80);
    run_load("lbu", 1'b0, 3'b100, 32'h0000_0203, 5'd13, 32'h80FF_1234, 32'h0000_0080);
    run_load("lh", 1'b0, 3'b001, 32'h0000_0102, 5'd6, 32'hBEEF_0000, 32'hFFFF_BEEF);
    run_load("lhu", 1'b0, 3'b101, 32'h0000_0102, 5'd6, 32'hBEEF_0000, 32'h0000_BEEF);
    run_load("lb1", 1'b0, 3'b000, 32'h0000_0011, 5'd2, 32'h0000_7F00, 32'h0000_007F);
    run_load("lw_rd0_both", 1'b1, 3'b010, 32'h0000_0104, 5'd0, 32'h1122_3344, 32'h1122_3344);
    run_store("sb", 3'b000, 32'h0000_0003, 32'h0000_00AB, 0, 32'hABAB_ABAB, 4'b1000);
    run_store("sb1", 3'b000, 32'h0000_0001, 32'h0000_00CD, 1, 32'hCDCD_CDCD, 4'b0010);
    run_store("sh", 3'b001, 32'h0000_0002, 32'h0000_1234, 1, 32'h1234_1234, 4'b1100);
    run_store("sh0", 3'b001, 32'h0000_0000, 32'h0000_5678, 0, 32'h5678_5678, 4'b0011);

    run_reject("rej lw_0x101", 1'b1, 3'b010, 32'h0000_0101);
    run_reject("rej sh_0x001", 1'b0, 3'b001, 32'h0000_0001);
    run_reject("rej load_f3_011", 1'b1, 3'b011, 32'h0000_0000);
    run_reject("rej store_f3_100", 1'b0, 3'b100, 32'h0000_0000);

    // Reset while a load is waiting for its ack, then a stale ack.
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd5);
    check("mid req_before", mem_bus.mem_req, 1);
    #2 rst = 1'b0;
    #1;
    check("mid req_async", mem_bus.mem_req, 0);
    check("mid ready_async", ex_ready, 1);
    check("mid wb_data_async", wb_data, 0);
    check("mid wb_add_async", wb_add, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_ack(32'hAAAA_5555);
    check("stale wb_en", wb_en, 0);
    check("stale req", mem_bus.mem_req, 0);
    check("stale ready", ex_ready, 1);
    check("stale wb_data", wb_data, 0);
    @(negedge clk);
    check("stale wb_en_late", wb_en, 0);
    run_load("lw_after_rst", 1'b0, 3'b010, 32'h0000_0000, 5'd7, 32'hCAFE_F00D, 32'hCAFE_F00D);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
